rename_recovery_ctrl: RTL and testbench

//   Sequences branch-mispredict recovery around the rename stage.
//   - On a committed mispredict it gates decode->rename traffic and pulses a pipeline flush.
//   - It then waits for in-flight functional-unit work to drain and redirects fetch to the resolved PC.
//   - Sits between the decoder, the rename stage, the commit/ROB, and fetch.
//   - Also keeps a saturating mispredict counter and a sticky drain-timeout flag.

---
 rtl/rename_recovery_ctrl.sv | 115 +++++++++++
 tb/tb_rename_recovery_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the rename stage.
// Runs IDLE -> FLUSH -> DRAIN -> REDIRECT and gates decode traffic while it recovers.
module rename_recovery_ctrl #(
  parameter int WORD_SIZE_P   = 16,
  parameter int FLUSH_CYCLES  = 2,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   commit_v_i,
  input  logic                   mispredict_i,
  input  logic [WORD_SIZE_P-1:0] resolved_pc_i,
  input  logic                   decoded_v_i,
  input  logic                   rename_ready_i,
  output logic                   decoded_v_o,
  output logic                   decode_ready_o,
  input  logic                   pipe_idle_i,
  output logic                   flush_o,
  output logic                   redirect_v_o,
  output logic [WORD_SIZE_P-1:0] redirect_pc_o,
  input  logic                   redirect_ready_i,
  output logic                   recovering_o,
  output logic [CNT_WIDTH-1:0]   mispredict_cnt_o,
  output logic                   drain_timeout_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int DW = $clog2(DRAIN_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} state_t;

  state_t                 state_reg, state_next;
  logic [FW-1:0]          flush_cnt_reg, flush_cnt_next;
  logic [DW-1:0]          drain_cnt_reg, drain_cnt_next;
  logic [WORD_SIZE_P-1:0] pc_reg, pc_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   timeout_reg, timeout_next;
  logic                   trig;
  logic                   idle;

  assign trig = commit_v_i & mispredict_i;
  assign idle = (state_reg == IDLE);

  // Gating must bite in the trigger cycle itself, before the state changes.
  assign decoded_v_o    = decoded_v_i & idle & ~trig;
  assign decode_ready_o = rename_ready_i & idle & ~trig;

  assign flush_o          = (state_reg == FLUSH);
  assign redirect_v_o     = (state_reg == REDIRECT);
  assign recovering_o     = ~idle;
  assign redirect_pc_o    = pc_reg;
  assign mispredict_cnt_o = cnt_reg;
  assign drain_timeout_o  = timeout_reg;

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    pc_next        = pc_reg;
    cnt_next       = cnt_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          pc_next        = resolved_pc_i;
          if (cnt_reg != {CNT_WIDTH{1'b1}}) cnt_next = cnt_reg + 1'b1;
          flush_cnt_next = FW'(FLUSH_CYCLES - 1);
          state_next     = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == '0) begin
          drain_cnt_next = '0;
          state_next     = DRAIN;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_idle_i) begin
          state_next = REDIRECT;
        end else if (drain_cnt_reg == DW'(DRAIN_TIMEOUT - 1)) begin
          timeout_next = 1'b1;
          state_next   = REDIRECT;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      drain_cnt_reg <= '0;
      pc_reg        <= '0;
      cnt_reg       <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      pc_reg        <= pc_next;
      cnt_reg       <= cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Scenario bench for rename_recovery_ctrl: expected redirects queued at trigger time,
// popped when the DUT raises redirect_v_o. A CNT_WIDTH=2 copy shares stimulus for saturation.
module tb_rename_recovery_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        commit_v = 1'b0, mispredict = 1'b0;
  logic [15:0] resolved_pc = '0;
  logic        decoded_v = 1'b0, rename_ready = 1'b0;
  logic        pipe_idle = 1'b0, redirect_ready = 1'b0;

  logic        decoded_v_o, decode_ready_o, flush_o, redirect_v_o, recovering_o, drain_timeout_o;
  logic [15:0] redirect_pc_o, cnt_o;
  logic        s_decoded_v_o, s_decode_ready_o, s_flush_o, s_redirect_v_o, s_recovering_o, s_timeout_o;
  logic [15:0] s_redirect_pc_o;
  logic [1:0]  s_cnt_o;

  rename_recovery_ctrl dut (
    .clk_i(clk), .reset_i(reset_i), .commit_v_i(commit_v), .mispredict_i(mispredict),
    .resolved_pc_i(resolved_pc), .decoded_v_i(decoded_v), .rename_ready_i(rename_ready),
    .decoded_v_o(decoded_v_o), .decode_ready_o(decode_ready_o), .pipe_idle_i(pipe_idle),
    .flush_o(flush_o), .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready), .recovering_o(recovering_o),
    .mispredict_cnt_o(cnt_o), .drain_timeout_o(drain_timeout_o)
  );

  rename_recovery_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .commit_v_i(commit_v), .mispredict_i(mispredict),
    .resolved_pc_i(resolved_pc), .decoded_v_i(decoded_v), .rename_ready_i(rename_ready),
    .decoded_v_o(s_decoded_v_o), .decode_ready_o(s_decode_ready_o), .pipe_idle_i(pipe_idle),
    .flush_o(s_flush_o), .redirect_v_o(s_redirect_v_o), .redirect_pc_o(s_redirect_pc_o),
    .redirect_ready_i(redirect_ready), .recovering_o(s_recovering_o),
    .mispredict_cnt_o(s_cnt_o), .drain_timeout_o(s_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];
  int   model_cnt = 0;
  int   model_sat = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic trigger(input logic [15:0] pc);
    exp_t e;
    commit_v = 1'b1;
    mispredict = 1'b1;
    resolved_pc = pc;
    if (model_cnt < 65535) model_cnt++;
    if (model_sat < 3) model_sat++;
    e.pc  = pc;
    e.cnt = 16'(model_cnt);
    e.sat = 2'(model_sat);
    sb.push_back(e);
  endtask

  task automatic wait_redirect(input int max_cycles, output int cycles);
    cycles = 0;
    while (!redirect_v_o && cycles < max_cycles) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (recovering_o !== 1'b0) begin errors++; $display("FAIL reset_recovering: got %b want 0", recovering_o); end
    checks++; if (flush_o !== 1'b0 || redirect_v_o !== 1'b0) begin errors++; $display("FAIL reset_flush_redirect: got %b%b want 00", flush_o, redirect_v_o); end
    checks++; if (redirect_pc_o !== 16'h0 || cnt_o !== 16'h0) begin errors++; $display("FAIL reset_pc_cnt: got %h/%h want 0000/0000", redirect_pc_o, cnt_o); end
    checks++; if (drain_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", drain_timeout_o); end
    tick(); tick();
    reset_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    pipe_idle = 1'b1; redirect_ready = 1'b1; decoded_v = 1'b1; rename_ready = 1'b1;
    trigger(16'h0040);
    #1;
    checks++; if (decoded_v_o !== 1'b0 || decode_ready_o !== 1'b0) begin errors++; $display("FAIL gate_trig_cycle: got %b%b want 00", decoded_v_o, decode_ready_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL flush_trig_cycle: got %b want 0", flush_o); end
    tick();
    commit_v = 1'b0; mispredict = 1'b0; resolved_pc = 16'h1234;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++; if (flush_o !== (c == 1 || c == 2)) begin errors++; $display("FAIL basic_flush c%0d: got %b want %b", c, flush_o, (c == 1 || c == 2)); end
      checks++; if (redirect_v_o !== (c == 4)) begin errors++; $display("FAIL basic_redirect_v c%0d: got %b want %b", c, redirect_v_o, (c == 4)); end
      checks++; if (recovering_o !== (c < 5)) begin errors++; $display("FAIL basic_recovering c%0d: got %b want %b", c, recovering_o, (c < 5)); end
      checks++; if (decoded_v_o !== (c == 5) || decode_ready_o !== (c == 5)) begin errors++; $display("FAIL basic_gate c%0d: got %b%b want %b%b", c, decoded_v_o, decode_ready_o, (c == 5), (c == 5)); end
      if (c == 4) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL basic_sb: got empty queue want entry"); end
        else begin
          e = sb.pop_front();
          $display("redirect pc=%h cnt=%0d (expected pc=%h cnt=%0d)", redirect_pc_o, cnt_o, e.pc, e.cnt);
          if (redirect_pc_o !== e.pc || cnt_o !== e.cnt) begin errors++; $display("FAIL basic_redirect: got %h/%0d want %h/%0d", redirect_pc_o, cnt_o, e.pc, e.cnt); end
        end
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_ignored_trig();
    exp_t e;
    int   cyc;
    tick();
    pipe_idle = 1'b0; redirect_ready = 1'b1;
    trigger(16'h0040);
    tick();
    resolved_pc = 16'h0080;  // trigger kept asserted with a new PC through recovery
    tick(); tick();
    pipe_idle = 1'b1;
    wait_redirect(20, cyc);
    checks++;
    if (!redirect_v_o) begin errors++; $display("FAIL ignored_timeout: got no redirect want redirect"); end
    else if (sb.size() == 0) begin errors++; $display("FAIL ignored_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      $display("redirect pc=%h cnt=%0d (expected pc=%h cnt=%0d)", redirect_pc_o, cnt_o, e.pc, e.cnt);
      if (redirect_pc_o !== e.pc || cnt_o !== e.cnt) begin errors++; $display("FAIL ignored_redirect: got %h/%0d want %h/%0d", redirect_pc_o, cnt_o, e.pc, e.cnt); end
    end
    commit_v = 1'b0; mispredict = 1'b0;
    tick(); #1;
    checks++; if (recovering_o !== 1'b0 || cnt_o !== 16'd2 || redirect_pc_o !== 16'h0040) begin errors++; $display("FAIL ignored_after: got rec=%b cnt=%0d pc=%h want 0/2/0040", recovering_o, cnt_o, redirect_pc_o); end
  endtask

  task automatic test_no_commit();
    tick();
    commit_v = 1'b0; mispredict = 1'b1; #1;
    checks++; if (decoded_v_o !== 1'b1) begin errors++; $display("FAIL nocommit_gate: got %b want 1", decoded_v_o); end
    tick();
    commit_v = 1'b1; mispredict = 1'b0;
    tick(); tick(); #1;
    checks++; if (recovering_o !== 1'b0 || cnt_o !== 16'd2) begin errors++; $display("FAIL nocommit_state: got rec=%b cnt=%0d want 0/2", recovering_o, cnt_o); end
    commit_v = 1'b0;
  endtask

  task automatic test_timeout_and_stall();
    exp_t e;
    int   cyc;
    bit   early;
    tick();
    pipe_idle = 1'b0; redirect_ready = 1'b0;
    trigger(16'h0100);
    tick();
    commit_v = 1'b0; mispredict = 1'b0;
    cyc = 1; early = 0;
    while (!redirect_v_o && cyc < 200) begin
      if (drain_timeout_o) early = 1;
      tick();
      cyc++;
    end
    checks++; if (cyc !== 67) begin errors++; $display("FAIL timeout_latency: got %0d want 67", cyc); end
    checks++; if (early !== 1'b0 || drain_timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_flag: got early=%b flag=%b want 0/1", early, drain_timeout_o); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL timeout_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      $display("redirect pc=%h cnt=%0d (expected pc=%h cnt=%0d)", redirect_pc_o, cnt_o, e.pc, e.cnt);
      if (redirect_pc_o !== e.pc || cnt_o !== e.cnt) begin errors++; $display("FAIL timeout_redirect: got %h/%0d want %h/%0d", redirect_pc_o, cnt_o, e.pc, e.cnt); end
    end
    pipe_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (redirect_v_o !== 1'b1 || redirect_pc_o !== 16'h0100) begin errors++; $display("FAIL stall_hold %0d: got v=%b pc=%h want 1/0100", i, redirect_v_o, redirect_pc_o); end
      tick();
    end
    redirect_ready = 1'b1;
    tick(); #1;
    checks++; if (redirect_v_o !== 1'b0 || recovering_o !== 1'b0) begin errors++; $display("FAIL stall_release: got v=%b rec=%b want 0/0", redirect_v_o, recovering_o); end
    checks++; if (drain_timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", drain_timeout_o); end
  endtask

  task automatic test_reset_mid_drain();
    tick();
    pipe_idle = 1'b0;
    trigger(16'h0200);
    tick();
    commit_v = 1'b0; mispredict = 1'b0;
    tick(); tick(); #1;
    checks++; if (recovering_o !== 1'b1 || flush_o !== 1'b0) begin errors++; $display("FAIL drain_state: got rec=%b flush=%b want 1/0", recovering_o, flush_o); end
    #1 reset_i = 1'b0;
    #1;
    checks++; if (recovering_o !== 1'b0 || cnt_o !== 16'h0 || redirect_pc_o !== 16'h0 || drain_timeout_o !== 1'b0) begin errors++; $display("FAIL async_reset: got rec=%b cnt=%h pc=%h to=%b want 0/0000/0000/0", recovering_o, cnt_o, redirect_pc_o, drain_timeout_o); end
    checks++; if (s_recovering_o !== 1'b0 || s_cnt_o !== 2'd0) begin errors++; $display("FAIL async_reset_sat: got rec=%b cnt=%0d want 0/0", s_recovering_o, s_cnt_o); end
    sb.delete();
    model_cnt = 0; model_sat = 0;
    tick(); tick();
    reset_i = 1'b1;
    pipe_idle = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_saturation();
    exp_t e;
    int   cyc;
    redirect_ready = 1'b1; pipe_idle = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      trigger(16'(n * 16'h0010));
      tick();
      commit_v = 1'b0; mispredict = 1'b0;
      wait_redirect(10, cyc);
      checks++;
      if (!redirect_v_o || sb.size() == 0) begin errors++; $display("FAIL sat_redirect %0d: got v=%b q=%0d want redirect", n, redirect_v_o, sb.size()); end
      else begin
        e = sb.pop_front();
        $display("redirect pc=%h cnt=%0d sat=%0d (expected pc=%h cnt=%0d sat=%0d)", redirect_pc_o, cnt_o, s_cnt_o, e.pc, e.cnt, e.sat);
        if (redirect_pc_o !== e.pc || cnt_o !== e.cnt || s_cnt_o !== e.sat) begin errors++; $display("FAIL sat_values %0d: got %h/%0d/%0d want %h/%0d/%0d", n, redirect_pc_o, cnt_o, s_cnt_o, e.pc, e.cnt, e.sat); end
      end
      tick();
    end
    #1;
    checks++; if (s_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d want 3", s_cnt_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignored_trig();
    test_no_commit();
    test_timeout_and_stall();
    test_reset_mid_drain();
    test_back_to_back_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
